lsu_stage: RTL
==============

Name: lsu_stage

Overview:
- Load/store stage directly downstream of the execute unit.
- Takes the EXU result as the effective address (or as the pass-through result for non-memory ops) together with rs2 data and the destination register.
- Performs at most one data-memory access over a valid/ready request channel and a response channel, then hands a writeback record to the WBU over a valid/ready handshake.
- Multi-cycle and non-pipelined: one instruction in flight.

Parameters:
- TIMEOUT, 255, cycles to wait for mem_resp_valid before flagging an error; 0 disables the timeout.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  EXU record valid
- in_ready  output  1  stage can accept a record
- in_addr  input  32  EXU_data: effective address, or the result for op NONE
- in_wdata  input  32  store data (rs2)
- in_rd  input  5  destination register
- in_op  input  4  operation: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW; all other codes illegal
- out_valid  output  1  writeback record valid
- out_ready  input  1  WBU accepts the record
- out_data  output  32  writeback value
- out_rd  output  5  destination register
- out_wen  output  1  register write enable
- out_err  output  1  misaligned, illegal, bus-error or timeout
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts the request
- mem_req_addr  output  32  word-aligned address: {addr[31:2], 2'b00}
- mem_req_wen  output  1  1 = write, 0 = read
- mem_req_wdata  output  32  store data, shifted to the byte lane
- mem_req_wstrb  output  4  byte strobes; 0 for reads
- mem_resp_valid  input  1  response valid; always accepted, no ready signal
- mem_resp_rdata  input  32  full read word
- mem_resp_err  input  1  bus error

Behaviour:
- Reset (synchronous, active-high): state IDLE; timeout counter 0.
- Reset values of outputs: out_valid=0, mem_req_valid=0, out_data=0, out_rd=0, out_wen=0, out_err=0, mem_req_addr=0, mem_req_wen=0, mem_req_wdata=0, mem_req_wstrb=0.
- Reset mid-transaction: the in-flight op is abandoned. A late mem_resp_valid arriving in IDLE is ignored.
- States: IDLE, REQ, RESP, DONE.
- in_ready=1 only in IDLE.
- IDLE:
  - On in_valid&&in_ready, latch addr, wdata, rd, op.
  - Op NONE -> DONE with out_data=in_addr, out_wen=(rd!=0), out_err=0.
  - Illegal op, or misaligned access (H/HU/SH with addr[0]!=0; W/SW with addr[1:0]!=0) -> DONE with out_err=1, out_wen=0, out_data=0. No memory access is issued.
  - Otherwise -> REQ.
- REQ:
  - mem_req_valid=1. Address, wen, wdata and wstrb stay stable until mem_req_ready.
  - On mem_req_ready -> RESP; clear the timeout counter.
  - Store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
  - Store data: wdata<<(8*addr[1:0]).
- RESP:
  - mem_resp_valid seen in the same cycle as the request handshake is ignored; the earliest legal response is the cycle after.
  - On mem_resp_valid -> DONE.
  - Loads: byte/half selected by addr[1:0] (halfword by addr[1]); LB/LH sign-extend, LBU/LHU zero-extend; out_wen=(rd!=0).
  - Stores: out_data=0, out_wen=0.
  - mem_resp_err=1 -> out_err=1, out_wen=0, out_data=0.
  - Timeout: counter increments each RESP cycle without a response. When TIMEOUT!=0 and the counter reaches TIMEOUT -> DONE with out_err=1, out_wen=0.
- DONE:
  - out_valid=1. out_* held stable until out_ready.
  - On out_ready -> IDLE. No new input is accepted in the same cycle.
- Latency with input accepted at cycle T:
  - NONE/error: out_valid at T+1.
  - Memory op with mem_req_ready=1 at T+1 and response at T+2: out_valid at T+3.
- Backpressure: out_ready low holds DONE indefinitely; in_ready stays 0.

Test Plan:
- NONE: op=0, addr=0x1234, rd=5 -> out_valid at T+1, out_data=0x1234, out_wen=1. Same with rd=0 -> out_wen=0.
- LB at 0x80000003, mem word 0x80FF7F01 -> one read to 0x80000000, wstrb=0; out_data=0xFFFFFF80. LBU same -> 0x00000080. LH at 0x80000002 -> 0xFFFF80FF. LHU -> 0x000080FF.
- SH at 0x80000002, wdata=0xAAAABEEF -> mem_req_wen=1, wstrb=4'b1100, wdata=0xBEEF0000; out_wen=0, out_err=0.
- Stall handling: mem_req_ready low 3 cycles with stable request, response delayed 5 cycles, then out_ready low 2 cycles -> exactly one request, record held stable, in_ready=0 throughout.
- Errors: LW at 0x...02 -> no request issued, out_err=1 at T+1. mem_resp_err=1 -> out_err=1, out_wen=0. TIMEOUT=4 with no response -> out_err=1 after 4 RESP cycles.
- rst asserted in RESP, then a stale mem_resp_valid -> outputs at reset values, stays IDLE, in_ready=1.

Source files
------------

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module : lsu_stage
// Load/store stage: one data-memory access per EXU record, then a WBU record.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic [3:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd8;
  localparam logic [3:0] OP_SH   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [3:0]       r_op;
  logic [1:0]       r_addr_lo;
  logic [4:0]       r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_req_addr;
  logic             r_req_wen;
  logic [31:0]      r_req_wdata;
  logic [3:0]       r_req_wstrb;
  logic [31:0]      r_out_data;
  logic             r_out_wen;
  logic             r_out_err;

  logic        w_accept;
  logic        w_in_legal;
  logic        w_in_store;
  logic        w_in_half;
  logic        w_in_word;
  logic        w_in_bad;
  logic        w_in_none;
  logic [3:0]  w_in_strb;
  logic [31:0] w_in_wdata_sh;
  logic        w_timeout;
  logic        w_resp_store;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Input decode: legality, access size and alignment of the offered record.
  always_comb begin
    w_in_legal = 1'b1;
    w_in_store = 1'b0;
    w_in_half  = 1'b0;
    w_in_word  = 1'b0;
    w_in_strb  = 4'b0000;
    case (in_op)
      OP_NONE, OP_LB, OP_LBU: ;
      OP_LH, OP_LHU: w_in_half = 1'b1;
      OP_LW:         w_in_word = 1'b1;
      OP_SB: begin
        w_in_store = 1'b1;
        w_in_strb  = 4'b0001 << in_addr[1:0];
      end
      OP_SH: begin
        w_in_store = 1'b1;
        w_in_half  = 1'b1;
        w_in_strb  = 4'b0011 << in_addr[1:0];
      end
      OP_SW: begin
        w_in_store = 1'b1;
        w_in_word  = 1'b1;
        w_in_strb  = 4'b1111;
      end
      default: w_in_legal = 1'b0;
    endcase
  end

  assign w_accept      = in_valid && (r_state == S_IDLE);
  assign w_in_none     = (in_op == OP_NONE);
  assign w_in_bad      = !w_in_legal || (w_in_half && in_addr[0]) || (w_in_word && (in_addr[1:0] != 2'b00));
  assign w_in_wdata_sh = in_wdata << {in_addr[1:0], 3'b000};

  // Response-side load extraction from the latched op and byte offset.
  assign w_resp_store = (r_op == OP_SB) || (r_op == OP_SH) || (r_op == OP_SW);
  assign w_byte       = mem_resp_rdata[{r_addr_lo, 3'b000} +: 8];
  assign w_half       = r_addr_lo[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];

  always_comb begin
    case (r_op)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'd0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_resp_rdata;
    endcase
  end

  assign w_timeout = (TIMEOUT != 0) && !mem_resp_valid && (r_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = (w_in_none || w_in_bad) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_resp_valid || w_timeout) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (r_state == S_IDLE);
    mem_req_valid = (r_state == S_REQ);
    out_valid     = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= OP_NONE;
      r_addr_lo   <= 2'b00;
      r_rd        <= 5'd0;
      r_cnt       <= '0;
      r_req_addr  <= 32'd0;
      r_req_wen   <= 1'b0;
      r_req_wdata <= 32'd0;
      r_req_wstrb <= 4'b0000;
      r_out_data  <= 32'd0;
      r_out_wen   <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= in_op;
            r_addr_lo <= in_addr[1:0];
            r_rd      <= in_rd;
            if (w_in_none) begin
              r_out_data <= in_addr;
              r_out_wen  <= (in_rd != 5'd0);
              r_out_err  <= 1'b0;
            end else if (w_in_bad) begin
              r_out_data <= 32'd0;
              r_out_wen  <= 1'b0;
              r_out_err  <= 1'b1;
            end else begin
              r_req_addr  <= {in_addr[31:2], 2'b00};
              r_req_wen   <= w_in_store;
              r_req_wdata <= w_in_store ? w_in_wdata_sh : 32'd0;
              r_req_wstrb <= w_in_strb;
              r_out_data  <= 32'd0;
              r_out_wen   <= 1'b0;
              r_out_err   <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_cnt <= '0;
          end
        end
        S_RESP: begin
          if (mem_resp_valid) begin
            if (mem_resp_err || w_resp_store) begin
              r_out_data <= 32'd0;
              r_out_wen  <= 1'b0;
              r_out_err  <= mem_resp_err;
            end else begin
              r_out_data <= w_load_data;
              r_out_wen  <= (r_rd != 5'd0);
              r_out_err  <= 1'b0;
            end
          end else if (w_timeout) begin
            r_out_data <= 32'd0;
            r_out_wen  <= 1'b0;
            r_out_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data      = r_out_data;
  assign out_rd        = r_rd;
  assign out_wen       = r_out_wen;
  assign out_err       = r_out_err;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_wen   = r_req_wen;
  assign mem_req_wdata = r_req_wdata;
  assign mem_req_wstrb = r_req_wstrb;

endmodule
`default_nettype wire
